// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM state codes and the default operand width.
package ex_muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DIV0 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // Even op codes are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {hi, multiplier} or
// restoring shift-subtract divide on {remainder, dividend/quotient}.
module muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    acc_out = acc_in;
    add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff    = rem_sh - {1'b0, operand};
    if (div) begin
      // Borrow out of the extra bit means the trial subtraction went negative.
      if (diff[WIDTH]) acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      else             acc_out = {diff[WIDTH-1:0],   acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {add_sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply / multiply-accumulate / divide unit: WIDTH cycles per
// operation, with sign handling, annul and a one-cycle ready pulse.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               neg_res, neg_rem;
  logic [2*WIDTH-1:0] acc, hilo_q, acc_step, prod, final_res;
  logic [WIDTH-1:0]   operand, mag1, mag2, quo, rem;
  logic               sign1, sign2, accept, last_iter, div_q;

  assign sign1     = op_is_signed(op_i) & opdata1_i[WIDTH-1];
  assign sign2     = op_is_signed(op_i) & opdata2_i[WIDTH-1];
  assign mag1      = sign1 ? -opdata1_i : opdata1_i;
  assign mag2      = sign2 ? -opdata2_i : opdata2_i;
  assign accept    = (state == S_IDLE) && start_i && !annul_i;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign div_q     = op_is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (div_q),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (acc_step)
  );

  // Final result is formed from the last iteration's output so it can be
  // registered on the same edge that enters DONE.
  always_comb begin
    prod = neg_res ? -acc_step : acc_step;
    quo  = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem  = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_DIV, OP_DIVU:   final_res = {rem, quo};
      OP_MADD, OP_MADDU: final_res = hilo_q + prod;
      OP_MSUB, OP_MSUBU: final_res = hilo_q - prod;
      default:           final_res = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including the
    // operand/accumulator copies, so no stale data survives a reset.
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      hilo_q   <= '0;
      operand  <= '0;
      result_o <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: if (accept) begin
          op_q    <= op_i;
          acc     <= {{WIDTH{1'b0}}, mag1};
          operand <= mag2;
          neg_res <= sign1 ^ sign2;
          neg_rem <= sign1;
          hilo_q  <= hilo_i;
          cnt     <= '0;
          state   <= (op_is_div(op_i) && opdata2_i == '0) ? S_DIV0 : S_RUN;
        end
        S_RUN: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              result_o <= final_res;
              state    <= S_DONE;
            end
          end
        end
        S_DIV0: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else begin
            result_o <= '0;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state == S_DONE);
  assign stall_o = accept || (state == S_RUN) || (state == S_DIV0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32): scoreboard of expected
// results and latencies, popped by a monitor on every ready_o pulse.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         annul_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] opdata1_i = '0;
  logic [W-1:0] opdata2_i = '0;
  logic [2*W-1:0] hilo_i = '0;
  logic [2*W-1:0] result_o;
  logic         ready_o;
  logic         stall_o;

  ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .hilo_i    (hilo_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [63:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (ready_o) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL spurious_ready: ready_o=1 at cycle %0d with nothing pending, result_o=%h", cyc, result_o);
      end else begin
        mon_e = sb.pop_front();
        if (result_o !== mon_e.res)
          $display("FAIL result: got %h expected %h", result_o, mon_e.res);
        else
          passed++;
        checks++;
        if (cyc - mon_e.acc_cyc !== mon_e.lat)
          $display("FAIL latency: got %0d expected %0d", cyc - mon_e.acc_cyc, mon_e.lat);
        else
          passed++;
      end
    end
  end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] h);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    if (op[0]) p = {32'b0, a} * {32'b0, b};
    else       p = sa * sbv;
    case (op)
      OP_DIV: begin
        if (b == 0) return 64'd0;
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU:           return (b == 0) ? 64'd0 : {a % b, a / b};
      OP_MADD, OP_MADDU: return h + p;
      OP_MSUB, OP_MSUBU: return h - p;
      default:           return p;
    endcase
  endfunction

  // Drives a request in the current cycle; optionally records what must come back.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h, input logic [63:0] e, input bit track);
    op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h; start_i = 1'b1;
    if (track) begin
      sb.push_back('{res: e, acc_cyc: cyc, lat: (op_is_div(op) && b == 0) ? 2 : 33});
      last_exp = e;
    end
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), n);
      sb.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, input logic [63:0] e);
    @(posedge clk); #1;
    issue(op, a, b, h, e, 1'b1);
    release_start();
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({result_o, ready_o, stall_o} !== {64'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got result=%h ready=%b stall=%b expected 0/0/0", result_o, ready_o, stall_o);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_divu_timing();
    @(posedge clk); #1;
    issue(OP_DIVU, 32'd100, 32'd7, 64'd0, {32'h2, 32'hE}, 1'b1);
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) $display("FAIL stall_accept: got %b expected 1", stall_o);
    else passed++;
    release_start();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      checks++;
      if ({stall_o, ready_o} !== 2'b10)
        $display("FAIL stall_run[%0d]: got stall=%b ready=%b expected 1/0", i, stall_o, ready_o);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if ({stall_o, ready_o} !== 2'b01)
      $display("FAIL stall_done: got stall=%b ready=%b expected 0/1", stall_o, ready_o);
    else passed++;
    wait_idle();
  endtask

  task automatic test_signed_div();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 64'd0, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'd0, {32'h00000000, 32'h80000000});
    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'd0, {32'h00000001, 32'hFFFFFFFD});
  endtask

  task automatic test_mult();
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h2, 64'd0, {32'hFFFFFFFF, 32'hFFFFFFFE});
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 64'd0, {32'h00000001, 32'hFFFFFFFE});
  endtask

  task automatic test_madd_msub();
    run_op(OP_MADDU, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, 64'h00000001_00000000);
    run_op(OP_MSUB, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF);
    run_op(OP_MADD, 32'hFFFFFFFF, 32'd3, 64'd10, 64'd7);
  endtask

  task automatic test_div0();
    run_op(OP_DIVU, 32'd5, 32'd0, 64'd0, 64'd0);
    // annul during DONE must not suppress the pulse
    @(posedge clk); #1;
    issue(OP_DIV, 32'hFFFFFFFD, 32'd0, 64'd0, 64'd0, 1'b1);
    release_start();
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) $display("FAIL stall_in_done: got %b expected 0", stall_o);
    else passed++;
    @(posedge clk); #1;
    annul_i = 1'b0;
    wait_idle();
  endtask

  task automatic test_annul_reset();
    @(posedge clk); #1;
    issue(OP_MULT, 32'd3, 32'd5, 64'd0, 64'd0, 1'b0);
    release_start();
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_o, ready_o, result_o} !== {1'b0, 1'b0, last_exp})
      $display("FAIL after_annul: got stall=%b ready=%b result=%h expected 0/0/%h", stall_o, ready_o, result_o, last_exp);
    else passed++;
    issue(OP_MULTU, 32'd6, 32'd7, 64'd0, 64'd42, 1'b1);
    #1;
    checks++;
    if (stall_o !== 1'b1) $display("FAIL restart_after_annul: got stall=%b expected 1", stall_o);
    else passed++;
    release_start();
    wait_idle();

    @(posedge clk); #1;
    issue(OP_MULTU, 32'd9, 32'd9, 64'd0, 64'd0, 1'b0);
    release_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_o, ready_o, result_o} !== {1'b0, 1'b0, 64'd0})
      $display("FAIL after_reset: got stall=%b ready=%b result=%h expected 0/0/0", stall_o, ready_o, result_o);
    else passed++;
    issue(OP_DIVU, 32'd1000, 32'd10, 64'd0, {32'd0, 32'd100}, 1'b1);
    #1;
    checks++;
    if (stall_o !== 1'b1) $display("FAIL restart_after_reset: got stall=%b expected 1", stall_o);
    else passed++;
    release_start();
    wait_idle();
  endtask

  task automatic test_start_ignored();
    int extra = 0;
    @(posedge clk); #1;
    issue(OP_MULTU, 32'd11, 32'd13, 64'd0, 64'd143, 1'b1);
    release_start();
    repeat (5) @(posedge clk);
    #1;
    issue(OP_DIVU, 32'd50, 32'd0, 64'd0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle();
    repeat (40) begin
      @(negedge clk);
      if (ready_o) extra++;
    end
    checks++;
    if (extra !== 0) $display("FAIL start_queued: got %0d extra ready pulses expected 0", extra);
    else passed++;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] h;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      h  = {$urandom(), $urandom()};
      #1;
      issue(op, a, b, h, model(op, a, b, h), 1'b1);
      release_start();
      wait_idle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divu_timing();
    test_signed_div();
    test_mult();
    test_madd_msub();
    test_div0();
    test_annul_reset();
    test_start_ignored();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
